ifid_frontend: RTL and testbench

IFID_FRONTEND -- requirements
Module: ifid_frontend

---
 rtl/ifid_frontend_pkg.sv | 34 +++
 rtl/ifid_frontend_ifid_reg.sv | 34 +++
 rtl/ifid_frontend.sv | 78 +++++++
 tb/tb_ifid_frontend.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ifid_frontend_pkg.sv
// Shared pipeline definitions: fetch constants, hazard-unit control bundle and
// the IF/ID register layout with its hold/bubble/load decode.
package ifid_frontend_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef struct packed {
        logic en_if;
        logic en_ifid;
        logic nop_ifid;
    } hazard_ctl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_op_t;

    // A disabled IF/ID wins over any bubble request, including a redirect squash.
    function automatic ifid_op_t ifid_op(input hazard_ctl_t ctl, input logic redirect);
        if (!ctl.en_ifid)                return IFID_HOLD;
        else if (ctl.nop_ifid || redirect) return IFID_BUBBLE;
        else                             return IFID_LOAD;
    endfunction

endpackage

// File: rtl/ifid_frontend_ifid_reg.sv
// IF/ID pipeline register: holds, loads a bubble, or captures the fetched
// instruction together with its PC.
module ifid_reg
    import ifid_frontend_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  ifid_op_t    op,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output ifid_t       ifid
);

    ifid_t ifid_d, ifid_q;

    always_comb begin
        ifid_d = ifid_q;
        case (op)
            IFID_BUBBLE: ifid_d = '{pc: pc_in, inst: NOP_INST, valid: 1'b0};
            IFID_LOAD:   ifid_d = '{pc: pc_in, inst: inst_in,  valid: 1'b1};
            default:     ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ifid_q <= '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};
        else     ifid_q <= ifid_d;
    end

    assign ifid = ifid_q;

endmodule

// File: rtl/ifid_frontend.sv
// Fetch front end: PC register with redirect/advance/hold, IF/ID register and
// stall/bubble performance counters.
module ifid_frontend
    import ifid_frontend_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_IF,
    input  logic        en_IFID,
    input  logic        NOP_IFID,
    input  logic        PCSrc_EXMem,
    input  logic [31:0] Target_EXMem,
    input  logic [31:0] inst_in,
    output logic [31:0] PC_out,
    output logic [31:0] PC_out_IFID,
    output logic [31:0] inst_out_IFID,
    output logic        valid_IFID,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] pc_d, pc_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] bubble_cnt_d, bubble_cnt_q;
    logic [31:0] redirect_pc;
    hazard_ctl_t ctl;
    ifid_op_t    op;
    ifid_t       ifid;

    assign ctl         = '{en_if: en_IF, en_ifid: en_IFID, nop_ifid: NOP_IFID};
    assign op          = ifid_op(ctl, PCSrc_EXMem);
    assign redirect_pc = Target_EXMem & ~32'h3;

    // Redirect beats the stall so a resolved branch is never dropped.
    always_comb begin
        pc_d = pc_q;
        if (PCSrc_EXMem) pc_d = redirect_pc;
        else if (en_IF)  pc_d = pc_q + PC_INC;

        stall_cnt_d = stall_cnt_q;
        if (!en_IF) stall_cnt_d = stall_cnt_q + 32'd1;

        bubble_cnt_d = bubble_cnt_q;
        if (op == IFID_BUBBLE) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            stall_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    ifid_reg #(.NOP_INST(NOP_INST)) u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .pc_in   (pc_q),
        .inst_in (inst_in),
        .ifid    (ifid)
    );

    assign PC_out        = pc_q;
    assign PC_out_IFID   = ifid.pc;
    assign inst_out_IFID = ifid.inst;
    assign valid_IFID    = ifid.valid;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_ifid_frontend.sv
// Scoreboard bench for ifid_frontend: directed vectors push hand-computed
// expectations, an independent monitor pops and compares them.
module tb_ifid_frontend;

    typedef struct packed {
        int          id;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] stall;
        logic [31:0] bubble;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_IF, en_IFID, NOP_IFID, PCSrc_EXMem;
    logic [31:0] Target_EXMem, inst_in;
    logic [31:0] PC_out, PC_out_IFID, inst_out_IFID, stall_cnt, bubble_cnt;
    logic        valid_IFID;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_id = 0;
    event chk_ev;

    ifid_frontend dut (
        .clk           (clk),
        .rst           (rst),
        .en_IF         (en_IF),
        .en_IFID       (en_IFID),
        .NOP_IFID      (NOP_IFID),
        .PCSrc_EXMem   (PCSrc_EXMem),
        .Target_EXMem  (Target_EXMem),
        .inst_in       (inst_in),
        .PC_out        (PC_out),
        .PC_out_IFID   (PC_out_IFID),
        .inst_out_IFID (inst_out_IFID),
        .valid_IFID    (valid_IFID),
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %08h expected %08h", id, nm, act, exp);
        end
    endtask

    // Monitor: registered outputs are stable at the falling edge or on demand.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("PC_out",        e.id, PC_out,            e.pc);
                chk("PC_out_IFID",   e.id, PC_out_IFID,       e.ifpc);
                chk("inst_out_IFID", e.id, inst_out_IFID,     e.inst);
                chk("valid_IFID",    e.id, {31'h0, valid_IFID}, {31'h0, e.valid});
                chk("stall_cnt",     e.id, stall_cnt,         e.stall);
                chk("bubble_cnt",    e.id, bubble_cnt,        e.bubble);
            end
        end
    end

    task automatic push(input logic [31:0] pc, ifpc, inst, input logic v,
                        input logic [31:0] stall, bubble);
        q.push_back('{id: vec_id, pc: pc, ifpc: ifpc, inst: inst, valid: v,
                      stall: stall, bubble: bubble});
        vec_id++;
    endtask

    // Drive one vector, let one rising edge pass, queue the state expected after it.
    task automatic step(input logic r, eif, eifid, nop, br, input logic [31:0] tgt, ins,
                        input logic [31:0] pc, ifpc, inst, input logic v,
                        input logic [31:0] stall, bubble);
        rst = r; en_IF = eif; en_IFID = eifid; NOP_IFID = nop;
        PCSrc_EXMem = br; Target_EXMem = tgt; inst_in = ins;
        @(posedge clk);
        push(pc, ifpc, inst, v, stall, bubble);
        @(negedge clk);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00A0_0113;
    localparam logic [31:0] I2  = 32'h0010_0073;
    localparam logic [31:0] I3  = 32'h0000_0093;

    initial begin
        rst = 1'b1; en_IF = 1'b0; en_IFID = 1'b0; NOP_IFID = 1'b0;
        PCSrc_EXMem = 1'b0; Target_EXMem = 32'h0; inst_in = 32'h0;
        #1;
        push(32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
        ->chk_ev;
        // reset held across an edge with en_IF low: nothing counts
        step(1,0,0,0,0, 32'h0, 32'h0,   32'h0, 32'h0, NOP, 0, 0, 0);
        // straight-line fetch
        step(0,1,1,0,0, 32'h0, I0,      32'h4, 32'h0, I0, 1, 0, 0);
        step(0,1,1,0,0, 32'h0, I0,      32'h8, 32'h4, I0, 1, 0, 0);
        step(0,1,1,0,0, 32'h0, I0,      32'hC, 32'h8, I0, 1, 0, 0);
        // stall with IF/ID disabled: NOP request must not bubble
        step(0,0,0,1,0, 32'h0, I1,      32'hC, 32'h8, I0, 1, 1, 0);
        step(0,0,0,1,0, 32'h0, I1,      32'hC, 32'h8, I0, 1, 2, 0);
        step(0,1,1,0,0, 32'h0, I1,      32'h10, 32'hC, I1, 1, 2, 0);
        // bubbles while PC keeps advancing
        step(0,1,1,1,0, 32'h0, I0,      32'h14, 32'h10, NOP, 0, 2, 1);
        step(0,1,1,1,0, 32'h0, I0,      32'h18, 32'h14, NOP, 0, 2, 2);
        step(0,1,1,1,0, 32'h0, I0,      32'h1C, 32'h18, NOP, 0, 2, 3);
        // redirect during a stall, unaligned target
        step(0,0,1,0,1, 32'h103, I0,    32'h100, 32'h1C, NOP, 0, 3, 4);
        step(0,1,1,0,0, 32'h0, I2,      32'h104, 32'h100, I2, 1, 3, 4);
        // redirect with IF/ID disabled: IF/ID holds, no bubble counted
        step(0,1,0,0,1, 32'hFFFF_FFFE, I0, 32'hFFFF_FFFC, 32'h100, I2, 1, 3, 4);
        // PC wraps
        step(0,1,1,0,0, 32'h0, I3,      32'h0, 32'hFFFF_FFFC, I3, 1, 3, 4);
        // async reset pulse strictly between edges
        #1 rst = 1'b1;
        #1 push(32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
        ->chk_ev;
        #1 rst = 1'b0;
        // first edge after release fetches from RESET_PC
        step(0,1,1,0,0, 32'h0, I0,      32'h4, 32'h0, I0, 1, 0, 0);
        // redirect presented while reset held is discarded
        step(1,0,1,0,1, 32'h200, I1,    32'h0, 32'h0, NOP, 0, 0, 0);
        step(0,1,1,0,0, 32'h0, I1,      32'h4, 32'h0, I1, 1, 0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
